// File: rtl/moving_avg_mc_if.sv
// Sample-stream bundle for the multi-channel moving-average filter.
// Strobe semantics: input_strobe qualifies data_in for one cycle (no back-pressure); output_strobe is a one-cycle pulse qualifying data_out.
interface moving_avg_mc_if #(
  parameter int DATA_WIDTH       = 16,
  parameter int NUM_CH           = 2,
  parameter int MAX_WINDOW_SHIFT = 6
);
  localparam int SHIFT_W = $clog2(MAX_WINDOW_SHIFT + 1);

  logic                         enable;
  logic [SHIFT_W-1:0]           window_shift;
  logic [NUM_CH*DATA_WIDTH-1:0] data_in;
  logic                         input_strobe;
  logic [NUM_CH*DATA_WIDTH-1:0] data_out;
  logic                         output_strobe;
  logic                         window_full;

  modport master (
    output enable, window_shift, data_in, input_strobe,
    input  data_out, output_strobe, window_full
  );

  modport slave (
    input  enable, window_shift, data_in, input_strobe,
    output data_out, output_strobe, window_full
  );
endinterface

// File: rtl/moving_avg_mc.sv
// Multi-channel moving average over a runtime power-of-two window, sharing one strobe and window setting.
// Each channel keeps a running sum plus a circular delay line; a window change flushes all channels.
module moving_avg_mc #(
  parameter int DATA_WIDTH       = 16,
  parameter int NUM_CH           = 2,
  parameter int MAX_WINDOW_SHIFT = 6,
  parameter int ROUND            = 1
) (
  input  logic           clock,
  input  logic           reset,
  moving_avg_mc_if.slave bus
);
  localparam int DEPTH   = 1 << MAX_WINDOW_SHIFT;
  localparam int PTR_W   = MAX_WINDOW_SHIFT;
  localparam int FILL_W  = MAX_WINDOW_SHIFT + 1;
  localparam int SUM_W   = DATA_WIDTH + MAX_WINDOW_SHIFT;
  localparam int SHIFT_W = $clog2(MAX_WINDOW_SHIFT + 1);

  logic [SHIFT_W-1:0]           shift_q;
  logic [SHIFT_W-1:0]           shift_req;
  logic [PTR_W-1:0]             wr_ptr;
  logic [PTR_W-1:0]             rd_ptr;
  logic [FILL_W-1:0]            fill;
  logic [FILL_W-1:0]            fill_next;
  logic [FILL_W-1:0]            win_len;
  logic [SUM_W:0]               round_add;
  logic [NUM_CH*DATA_WIDTH-1:0] mean_next;
  logic [NUM_CH*DATA_WIDTH-1:0] data_out_q;
  logic                         output_strobe_q;
  logic                         window_full_q;
  logic                         window_change;
  logic                         accept;
  logic                         window_done;

  always_comb begin
    shift_req = bus.window_shift;
    if (bus.window_shift > SHIFT_W'(MAX_WINDOW_SHIFT)) shift_req = SHIFT_W'(MAX_WINDOW_SHIFT);
  end

  assign win_len       = FILL_W'(1) << shift_q;
  assign rd_ptr        = wr_ptr - win_len[PTR_W-1:0];
  assign window_change = (shift_req != shift_q);
  // A strobe landing in the flush cycle is dropped so the new window starts clean.
  assign accept        = bus.enable && bus.input_strobe && !window_change;
  assign fill_next     = (fill == win_len) ? fill : fill + 1'b1;
  assign window_done   = (fill_next == win_len);
  assign round_add     = (ROUND != 0 && shift_q != '0)
                       ? ({{SUM_W{1'b0}}, 1'b1} << (shift_q - 1'b1)) : '0;

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    logic signed [DATA_WIDTH-1:0] delay [DEPTH];
    logic signed [DATA_WIDTH-1:0] sample;
    logic signed [DATA_WIDTH-1:0] old;
    logic signed [SUM_W-1:0]      sum_q;
    logic signed [SUM_W-1:0]      sum_next;
    logic signed [SUM_W:0]        rounded;

    assign sample = bus.data_in[k*DATA_WIDTH +: DATA_WIDTH];
    assign old    = delay[rd_ptr];

    // Intermediate sum+new may wrap, but sum+new-old is a true window sum and fits SUM_W exactly.
    always_comb begin
      sum_next = sum_q + SUM_W'(sample);
      if (fill == win_len) sum_next = sum_q + SUM_W'(sample) - SUM_W'(old);
    end

    assign rounded = $signed({sum_next[SUM_W-1], sum_next}) + $signed(round_add);
    assign mean_next[k*DATA_WIDTH +: DATA_WIDTH] = DATA_WIDTH'(rounded >>> shift_q);

    always_ff @(posedge clock) begin
      if (accept) delay[wr_ptr] <= sample;
    end

    always_ff @(posedge clock) begin
      if (reset || window_change) sum_q <= '0;
      else if (accept)            sum_q <= sum_next;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      shift_q         <= '0;
      wr_ptr          <= '0;
      fill            <= '0;
      window_full_q   <= 1'b0;
      output_strobe_q <= 1'b0;
      data_out_q      <= '0;
    end else if (window_change) begin
      shift_q         <= shift_req;
      fill            <= '0;
      window_full_q   <= 1'b0;
      output_strobe_q <= 1'b0;
    end else begin
      output_strobe_q <= accept && window_done;
      if (accept) begin
        wr_ptr        <= wr_ptr + 1'b1;
        fill          <= fill_next;
        window_full_q <= window_done;
        if (window_done) data_out_q <= mean_next;
      end
    end
  end

  assign bus.data_out      = data_out_q;
  assign bus.output_strobe = output_strobe_q;
  assign bus.window_full   = window_full_q;
endmodule

// File: tb/tb_moving_avg_mc.sv
// Self-checking bench for moving_avg_mc: vector table, directed corner sequences,
// and randomized traffic checked against a sample-history reference model.
module tb_moving_avg_mc;
  localparam int DW  = 16;
  localparam int NCH = 2;
  localparam int MWS = 6;
  localparam int RND = 1;
  localparam int SW  = $clog2(MWS + 1);

  logic clock = 1'b0;
  logic reset;
  logic checking = 1'b0;

  moving_avg_mc_if #(.DATA_WIDTH(DW), .NUM_CH(NCH), .MAX_WINDOW_SHIFT(MWS)) bus ();

  moving_avg_mc #(.DATA_WIDTH(DW), .NUM_CH(NCH), .MAX_WINDOW_SHIFT(MWS), .ROUND(RND)) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  logic [NCH*DW-1:0] exp_q[$];
  logic [NCH*DW-1:0] exp_dout;
  logic              exp_strobe;
  logic              exp_full;
  int                hist[NCH][$];
  int                m_shift;

  task automatic check(input string name, input longint got, input longint exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  // Mean of a window sum with optional round-half-up, as floor((sum + R) / W).
  function automatic longint mean_of(input longint acc, input int s);
    longint w;
    longint num;
    longint q;
    w   = longint'(1) << s;
    num = acc + ((RND != 0 && s > 0) ? (longint'(1) << (s - 1)) : 0);
    q   = num / w;
    if ((num % w) != 0 && num < 0) q = q - 1;
    return q;
  endfunction

  // Reference model: keeps the accepted samples since the last flush and averages the newest W.
  always @(posedge clock) begin : ref_model
    int     s_req;
    int     w;
    longint acc;
    if (reset) begin
      m_shift    = 0;
      for (int k = 0; k < NCH; k++) hist[k].delete();
      exp_strobe = 1'b0;
      exp_full   = 1'b0;
      exp_dout   = '0;
      exp_q.delete();
    end else begin
      s_req = (int'(bus.window_shift) > MWS) ? MWS : int'(bus.window_shift);
      if (s_req != m_shift) begin
        m_shift    = s_req;
        for (int k = 0; k < NCH; k++) hist[k].delete();
        exp_strobe = 1'b0;
        exp_full   = 1'b0;
      end else if (bus.enable && bus.input_strobe) begin
        w = 1 << m_shift;
        for (int k = 0; k < NCH; k++) begin
          hist[k].push_back(int'($signed(bus.data_in[k*DW +: DW])));
          if (hist[k].size() > w) void'(hist[k].pop_front());
        end
        exp_full   = (hist[0].size() == w);
        exp_strobe = exp_full;
        if (exp_full) begin
          for (int k = 0; k < NCH; k++) begin
            acc = 0;
            foreach (hist[k][j]) acc += hist[k][j];
            exp_dout[k*DW +: DW] = DW'(mean_of(acc, m_shift));
          end
          exp_q.push_back(exp_dout);
        end
      end else begin
        exp_strobe = 1'b0;
      end
    end
  end

  always @(negedge clock) begin : scoreboard
    logic [NCH*DW-1:0] want;
    if (checking) begin
      check("output_strobe", bus.output_strobe, exp_strobe);
      check("window_full", bus.window_full, exp_full);
      check("data_out_held", bus.data_out, exp_dout);
      if (bus.output_strobe) begin
        if (exp_q.size() == 0) begin
          check("unexpected_output", bus.output_strobe, 0);
        end else begin
          want = exp_q.pop_front();
          check("scoreboard_data", bus.data_out, want);
        end
      end
    end
  end

  // Inputs change on the falling edge; returns at the next falling edge with outputs settled.
  task automatic step(input logic en, input int ws, input int d0, input int d1, input logic stb);
    bus.enable       = en;
    bus.window_shift = SW'(ws);
    bus.data_in      = {DW'(d1), DW'(d0)};
    bus.input_strobe = stb;
    @(negedge clock);
  endtask

  task automatic do_reset(input int ws);
    reset = 1'b1;
    step(1'b1, ws, 0, 0, 1'b0);
    check("reset_data_out", bus.data_out, 0);
    check("reset_output_strobe", bus.output_strobe, 0);
    check("reset_window_full", bus.window_full, 0);
    reset = 1'b0;
    step(1'b1, ws, 0, 0, 1'b0);
  endtask

  task automatic check_ch(input string name, input int e0, input int e1);
    check({name, "_ch0"}, $signed(bus.data_out[DW-1:0]), e0);
    check({name, "_ch1"}, $signed(bus.data_out[2*DW-1:DW]), e1);
  endtask

  typedef struct {
    int d0;
    int d1;
    bit reset_before;
    bit exp_valid;
    bit exp_full;
    int e0;
    int e1;
  } vec_t;

  vec_t vecs[16];

  initial begin
    reset            = 1'b1;
    bus.enable       = 1'b0;
    bus.window_shift = '0;
    bus.data_in      = '0;
    bus.input_strobe = 1'b0;
    @(negedge clock);
    checking = 1'b1;

    // Constant channels, then a ramp, both at W=4.
    for (int i = 0; i < 6; i++) vecs[i] = '{100, -7, i == 0, i >= 3, i >= 3, 100, -7};
    for (int i = 0; i < 10; i++) vecs[6+i] = '{i, -i, i == 0, i >= 3, i >= 3, i - 1, 2 - i};
    for (int i = 0; i < 16; i++) begin
      if (vecs[i].reset_before) do_reset(2);
      step(1'b1, 2, vecs[i].d0, vecs[i].d1, 1'b1);
      check($sformatf("vec%0d_strobe", i), bus.output_strobe, vecs[i].exp_valid);
      check($sformatf("vec%0d_full", i), bus.window_full, vecs[i].exp_full);
      if (vecs[i].exp_valid) check_ch($sformatf("vec%0d", i), vecs[i].e0, vecs[i].e1);
    end

    // W=1 passes samples straight through from the first strobe.
    do_reset(0);
    step(1'b1, 0, 123, -456, 1'b1);
    check("w1_strobe", bus.output_strobe, 1);
    check_ch("w1_data", 123, -456);

    // Window change mid-stream: the change-cycle strobe is dropped.
    do_reset(3);
    for (int i = 0; i < 20; i++) step(1'b1, 3, $urandom_range(0, 2000) - 1000, $urandom_range(0, 2000) - 1000, 1'b1);
    step(1'b1, 1, 1000, -1000, 1'b1);
    check("chg_cycle_strobe", bus.output_strobe, 0);
    check("chg_cycle_full", bus.window_full, 0);
    step(1'b1, 1, 5, -5, 1'b1);
    check("chg_first_strobe", bus.output_strobe, 0);
    step(1'b1, 1, 8, -8, 1'b1);
    check("chg_second_strobe", bus.output_strobe, 1);
    check_ch("chg_mean", 7, -6);

    // Full-scale inputs at the widest window.
    do_reset(6);
    for (int i = 0; i < 64; i++) step(1'b1, 6, 32767, -32768, 1'b1);
    check("fs_pos_strobe", bus.output_strobe, 1);
    check_ch("fs_pos", 32767, -32768);
    for (int i = 0; i < 64; i++) step(1'b1, 6, -32768, 32767, 1'b1);
    check_ch("fs_neg", -32768, 32767);

    // Random gaps, then enable held low with strobes present.
    do_reset(2);
    for (int i = 0; i < 20; i++) step(1'b1, 2, $urandom_range(0, 500), $urandom_range(0, 500), $urandom_range(0, 1) == 1);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 2, 30000, -30000, 1'b1);
      check("en_low_strobe", bus.output_strobe, 0);
    end
    for (int i = 0; i < 10; i++) step(1'b1, 2, $urandom_range(0, 500), $urandom_range(0, 500), 1'b1);

    // Mid-stream reset discards history.
    for (int i = 0; i < 10; i++) step(1'b1, 2, 9000, -9000, 1'b1);
    do_reset(2);
    step(1'b1, 2, 10, -10, 1'b1);
    step(1'b1, 2, 20, -20, 1'b1);
    step(1'b1, 2, 30, -30, 1'b1);
    check("post_reset_no_strobe", bus.output_strobe, 0);
    step(1'b1, 2, 41, -41, 1'b1);
    check("post_reset_strobe", bus.output_strobe, 1);
    check_ch("post_reset_mean", 25, -25);

    // Randomized traffic including window changes and out-of-range requests.
    begin
      int ws;
      int d0;
      int d1;
      ws = 3;
      do_reset(ws);
      for (int i = 0; i < 3000; i++) begin
        if ($urandom_range(0, 99) == 0) ws = $urandom_range(0, 7);
        d0 = $urandom_range(0, 65535) - 32768;
        d1 = ($urandom_range(0, 7) == 0) ? -32768 : $urandom_range(0, 65535) - 32768;
        step($urandom_range(0, 9) != 0, ws, d0, d1, $urandom_range(0, 2) != 0);
      end
    end

    step(1'b1, 0, 0, 0, 1'b0);
    step(1'b1, 0, 0, 0, 1'b0);
    check("exp_q_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
